// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: majority-vote deserializer for the fixed-slot
// pulse train of the serial signal generator, with ready/valid output.
module serial_frame_receiver #(
   parameter int WIDTH = 8,
   parameter int T2    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      T1,
   input  logic             signal_in,
   input  logic             data_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             data_err,
   output logic             data_valid,
   output logic [15:0]      glitch_cnt,
   output logic             idle_err,
   output logic             short_frame,
   output logic             overrun
);

   localparam int OW = $clog2(T2 + 2);
   localparam int SW = (T2 > 0) ? $clog2(T2 + 1) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [31:0]   DATA_LEN  = 32'((T2 + 1) * WIDTH);
   localparam logic [OW-1:0] ALL_ONES  = OW'(T2 + 1);
   localparam logic [OW:0]   HALF_REF  = (OW + 1)'(T2 + 1);
   localparam logic [SW-1:0] LAST_SLOT = SW'(T2);
   localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);

   logic [31:0]      frame_cnt;
   logic [SW-1:0]    slot;
   logic [BW-1:0]    bit_idx;
   logic [OW-1:0]    ones;
   logic [WIDTH-1:0] acc;
   logic             err_acc;

   logic             wrap;
   logic             in_data;
   logic             in_gap;
   logic             last_sample;
   logic             last_bit;
   logic             complete;
   logic             truncate;
   logic [OW-1:0]    ones_total;
   logic             bit_val;
   logic             split;
   logic [WIDTH-1:0] word;
   logic             word_err;
   logic             transfer;
   logic             can_load;

   // Frame position decode
   assign wrap        = (frame_cnt == T1);
   assign in_data     = (frame_cnt != '0) && (frame_cnt <= DATA_LEN);
   assign in_gap      = !in_data;
   assign last_sample = in_data && (slot == LAST_SLOT);
   assign last_bit    = (bit_idx == LAST_BIT);
   assign complete    = last_sample && last_bit;
   // A wrap at the completion cycle itself is a full frame
   assign truncate    = wrap && (frame_cnt < DATA_LEN);

   // Majority vote over the bit's samples, ties resolve to 0
   assign ones_total = ones + OW'(signal_in);
   assign bit_val    = {ones_total, 1'b0} > HALF_REF;
   assign split      = (ones_total != '0) && (ones_total != ALL_ONES);

   assign word     = {bit_val, acc[WIDTH-1:1]};
   assign word_err = err_acc | split;

   assign transfer = data_valid & data_ready;
   assign can_load = !data_valid | data_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (wrap) begin
         frame_cnt <= '0;
      end else begin
         frame_cnt <= frame_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || truncate) begin
         slot    <= '0;
         bit_idx <= '0;
         ones    <= '0;
         acc     <= '0;
         err_acc <= 1'b0;
      end else if (in_data) begin
         if (slot == LAST_SLOT) begin
            slot    <= '0;
            ones    <= '0;
            bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
            acc     <= last_bit ? '0 : word;
            err_acc <= last_bit ? 1'b0 : word_err;
         end else begin
            slot <= slot + 1'b1;
            ones <= ones_total;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out   <= '0;
         data_err   <= 1'b0;
         data_valid <= 1'b0;
      end else if (complete && can_load) begin
         data_out   <= word;
         data_err   <= word_err;
         data_valid <= 1'b1;
      end else if (transfer) begin
         data_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         glitch_cnt <= '0;
      end else if (last_sample && split && glitch_cnt != 16'hFFFF) begin
         glitch_cnt <= glitch_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idle_err    <= 1'b0;
         short_frame <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         idle_err    <= idle_err | (in_gap & signal_in);
         short_frame <= short_frame | truncate;
         overrun     <= overrun | (complete & !can_load);
      end
   end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: drives a generator-style pulse train and
// checks the receiver against a frame-level reference model.
module tb_serial_frame_receiver;

   localparam int WIDTH = 8;
   localparam int T2    = 2;
   localparam int HOLD  = T2 + 1;
   localparam int DLEN  = HOLD * WIDTH;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [31:0]      t1 = 32'd40;
   logic             signal_in = 1'b0;
   logic             data_ready = 1'b0;
   logic [WIDTH-1:0] data_out;
   logic             data_err;
   logic             data_valid;
   logic [15:0]      glitch_cnt;
   logic             idle_err;
   logic             short_frame;
   logic             overrun;

   serial_frame_receiver #(.WIDTH(WIDTH), .T2(T2)) dut (
      .clk(clk),
      .reset(reset),
      .T1(t1),
      .signal_in(signal_in),
      .data_ready(data_ready),
      .data_out(data_out),
      .data_err(data_err),
      .data_valid(data_valid),
      .glitch_cnt(glitch_cnt),
      .idle_err(idle_err),
      .short_frame(short_frame),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   // Reference model state
   int               f;
   int               cyc;
   bit               rand_words;
   logic [WIDTH-1:0] cur_word;
   bit               samp [DLEN];
   logic             m_valid;
   logic [WIDTH-1:0] m_out;
   logic             m_err;
   int               m_glitch;
   logic             m_idle;
   logic             m_short;
   logic             m_over;

   function automatic logic [WIDTH-1:0] next_word();
      if (rand_words) return WIDTH'($urandom);
      return WIDTH'(8'hA5);
   endfunction

   function automatic logic gen_bit(int fc);
      if (fc >= 1 && fc <= DLEN) return cur_word[(fc - 1) / HOLD];
      return 1'b0;
   endfunction

   function automatic int ones_in_bit(int b);
      int n;
      n = 0;
      for (int k = 0; k < HOLD; k++) n += int'(samp[b * HOLD + k]);
      return n;
   endfunction

   task automatic do_reset(input logic [31:0] new_t1, input bit rw);
      reset = 1'b1;
      t1 = new_t1;
      signal_in = 1'b0;
      data_ready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      rand_words = rw;
      f = 0;
      cyc = 0;
      m_valid = 1'b0;
      m_out = '0;
      m_err = 1'b0;
      m_glitch = 0;
      m_idle = 1'b0;
      m_short = 1'b0;
      m_over = 1'b0;
      cur_word = next_word();
   endtask

   // Drive one cycle of the line, clock it, and advance the model
   task automatic tick(input logic rdy, input logic flip, input logic force1);
      logic             v;
      int               cnt;
      logic [WIDTH-1:0] w;
      logic             e;
      v = (gen_bit(f) ^ flip) | force1;
      signal_in = v;
      data_ready = rdy;
      @(posedge clk);
      #1;
      if (f >= 1 && f <= DLEN) begin
         samp[f - 1] = v;
         if (f % HOLD == 0) begin
            cnt = ones_in_bit((f - 1) / HOLD);
            if (cnt != 0 && cnt != HOLD && m_glitch < 65535) m_glitch++;
         end
      end else if (v) begin
         m_idle = 1'b1;
      end
      if (f == DLEN) begin
         w = '0;
         e = 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt = ones_in_bit(i);
            w[i] = (2 * cnt > HOLD);
            if (cnt != 0 && cnt != HOLD) e = 1'b1;
         end
         if (!m_valid || rdy) begin
            m_valid = 1'b1;
            m_out = w;
            m_err = e;
         end else begin
            m_over = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      if (f == int'(t1)) begin
         if (f < DLEN) m_short = 1'b1;
         f = 0;
         cur_word = next_word();
      end else begin
         f++;
      end
      cyc++;
   endtask

   task automatic test_reset();
      do_reset(32'd40, 1'b0);
      compared++;
      if ({data_valid, data_out, data_err, glitch_cnt, idle_err,
           short_frame, overrun} !== '0) begin
         mismatched++;
         $display("FAIL reset_state: v=%b d=%h e=%b g=%0d i=%b s=%b o=%b want all 0",
                  data_valid, data_out, data_err, glitch_cnt, idle_err,
                  short_frame, overrun);
      end
   endtask

   task automatic test_basic();
      do_reset(32'd40, 1'b0);
      while (cyc < 72) begin
         tick(1'b1, 1'b0, 1'b0);
         compared++;
         if ({data_valid, data_out, data_err, glitch_cnt, idle_err,
              short_frame, overrun} !==
             {m_valid, m_out, m_err, m_glitch[15:0], m_idle, m_short, m_over}) begin
            mismatched++;
            $display("FAIL basic_model cyc=%0d: got v=%b d=%h e=%b g=%0d i=%b s=%b o=%b want v=%b d=%h e=%b g=%0d i=%b s=%b o=%b",
                     cyc, data_valid, data_out, data_err, glitch_cnt, idle_err,
                     short_frame, overrun, m_valid, m_out, m_err, m_glitch,
                     m_idle, m_short, m_over);
         end
         if (cyc == 24 || cyc == 25 || cyc == 66) begin
            compared++;
            if (data_valid !== (cyc != 24) ||
                (cyc != 24 && (data_out !== 8'hA5 || data_err !== 1'b0))) begin
               mismatched++;
               $display("FAIL basic_latency cyc=%0d: got v=%b d=%h e=%b want v=%b d=a5 e=0",
                        cyc, data_valid, data_out, data_err, cyc != 24);
            end
         end
      end
      compared++;
      if ({idle_err, short_frame, overrun, glitch_cnt} !== '0) begin
         mismatched++;
         $display("FAIL basic_flags: got i=%b s=%b o=%b g=%0d want 0",
                  idle_err, short_frame, overrun, glitch_cnt);
      end
   endtask

   task automatic test_overrun();
      do_reset(32'd40, 1'b0);
      while (cyc < 75) begin
         tick(cyc >= 70, 1'b0, 1'b0);
         if (cyc == 66 || cyc == 70) begin
            compared++;
            if (data_valid !== 1'b1 || data_out !== 8'hA5 || overrun !== 1'b1) begin
               mismatched++;
               $display("FAIL overrun_hold cyc=%0d: got v=%b d=%h o=%b want v=1 d=a5 o=1",
                        cyc, data_valid, data_out, overrun);
            end
         end
         if (cyc == 71) begin
            compared++;
            if (data_valid !== 1'b0) begin
               mismatched++;
               $display("FAIL overrun_drain cyc=71: got v=%b want v=0", data_valid);
            end
         end
      end
   endtask

   task automatic test_glitch();
      do_reset(32'd40, 1'b0);
      while (cyc < 26) begin
         tick(1'b1, cyc == 11, 1'b0);
         if (cyc == 25) begin
            compared++;
            if (data_valid !== 1'b1 || data_out !== 8'hA5 || data_err !== 1'b1 ||
                glitch_cnt !== 16'd1) begin
               mismatched++;
               $display("FAIL glitch_vote: got v=%b d=%h e=%b g=%0d want v=1 d=a5 e=1 g=1",
                        data_valid, data_out, data_err, glitch_cnt);
            end
         end
      end
   endtask

   task automatic test_short();
      logic saw_valid;
      saw_valid = 1'b0;
      do_reset(32'd20, 1'b0);
      while (cyc < 70) begin
         tick(1'b1, 1'b0, 1'b0);
         saw_valid |= data_valid;
         if (cyc == 20 || cyc == 21) begin
            compared++;
            if (short_frame !== (cyc == 21)) begin
               mismatched++;
               $display("FAIL short_flag cyc=%0d: got s=%b want s=%b",
                        cyc, short_frame, cyc == 21);
            end
         end
      end
      compared++;
      if (saw_valid !== 1'b0 || idle_err !== 1'b0 || overrun !== 1'b0) begin
         mismatched++;
         $display("FAIL short_no_word: got seen_v=%b i=%b o=%b want 0 0 0",
                  saw_valid, idle_err, overrun);
      end
   endtask

   task automatic test_idle();
      do_reset(32'd40, 1'b0);
      while (cyc < 67) begin
         tick(1'b1, 1'b0, cyc == 30);
         if (cyc == 30 || cyc == 31) begin
            compared++;
            if (idle_err !== (cyc == 31)) begin
               mismatched++;
               $display("FAIL idle_flag cyc=%0d: got i=%b want i=%b",
                        cyc, idle_err, cyc == 31);
            end
         end
         if (cyc == 66) begin
            compared++;
            if (data_valid !== 1'b1 || data_out !== 8'hA5 || data_err !== 1'b0) begin
               mismatched++;
               $display("FAIL idle_next_word: got v=%b d=%h e=%b want v=1 d=a5 e=0",
                        data_valid, data_out, data_err);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset(32'd40, 1'b0);
      while (cyc < 12) tick(1'b1, cyc == 5, cyc == 0);
      compared++;
      if (glitch_cnt !== 16'd1 || idle_err !== 1'b1) begin
         mismatched++;
         $display("FAIL midreset_pre: got g=%0d i=%b want g=1 i=1",
                  glitch_cnt, idle_err);
      end
      do_reset(32'd40, 1'b0);
      compared++;
      if ({data_valid, data_out, data_err, glitch_cnt, idle_err,
           short_frame, overrun} !== '0) begin
         mismatched++;
         $display("FAIL midreset_clear: got v=%b d=%h g=%0d i=%b want all 0",
                  data_valid, data_out, glitch_cnt, idle_err);
      end
      while (cyc < 26) begin
         tick(1'b1, 1'b0, 1'b0);
         if (cyc == 24 || cyc == 25) begin
            compared++;
            if (data_valid !== (cyc == 25) ||
                (cyc == 25 && (data_out !== 8'hA5 || data_err !== 1'b0))) begin
               mismatched++;
               $display("FAIL midreset_latency cyc=%0d: got v=%b d=%h e=%b want v=%b d=a5 e=0",
                        cyc, data_valid, data_out, data_err, cyc == 25);
            end
         end
      end
   endtask

   task automatic test_random();
      int t1_set [8];
      t1_set = '{24, 23, 0, 5, 30, 40, 63, 0};
      t1_set[7] = $urandom_range(0, 60);
      for (int r = 0; r < 8; r++) begin
         do_reset(32'(t1_set[r]), 1'b1);
         for (int n = 0; n < 150; n++) begin
            tick(($urandom % 4) != 0, ($urandom % 25) == 0, ($urandom % 40) == 0);
            compared++;
            if ({data_valid, data_out, data_err, glitch_cnt, idle_err,
                 short_frame, overrun} !==
                {m_valid, m_out, m_err, m_glitch[15:0], m_idle, m_short, m_over}) begin
               mismatched++;
               $display("FAIL random t1=%0d cyc=%0d: got v=%b d=%h e=%b g=%0d i=%b s=%b o=%b want v=%b d=%h e=%b g=%0d i=%b s=%b o=%b",
                        t1_set[r], cyc, data_valid, data_out, data_err, glitch_cnt,
                        idle_err, short_frame, overrun, m_valid, m_out, m_err,
                        m_glitch, m_idle, m_short, m_over);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_glitch();
      test_short();
      test_idle();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Deserializer paired with the serial signal generator on the same clock and reset. It recovers the WIDTH-bit word from the generator's pulse train (LSB first, each bit held T2+1 cycles, frame period T1+1 cycles) by majority vote per bit. It presents each word on a ready/valid interface with per-word and sticky error flags. Alignment is by shared reset; there is no start marker on the line.

## Interface
- WIDTH, 8, word width; must equal the generator's WIDTH
- T2, 2, bit hold parameter; each bit occupies T2+1 cycles on the line
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; must be the same reset that drives the generator
- T1  in  32  frame period minus one; same value as the generator; static between resets
- signal_in  in  1  generator output, registered, connected directly
- data_ready  in  1  consumer accepts data_out when high with data_valid
- data_out  out  WIDTH  recovered word; reset 0
- data_err  out  1  word contained at least one non-unanimous bit; valid with data_out; reset 0
- data_valid  out  1  word available; reset 0
- glitch_cnt  out  16  count of non-unanimous bits, saturating at 16'hFFFF; reset 0
- idle_err  out  1  sticky: a 1 was seen in a gap sample; reset 0
- short_frame  out  1  sticky: frame ended before all bits were sampled; reset 0
- overrun  out  1  sticky: a word completed while the holding register was full; reset 0

## Operation
- Cycle 0 is the first cycle with reset low. frame_cnt is 0 in cycle 0. At each edge it becomes 0 if it equals T1, else it increments by 1.
- signal_in during frame cycle f carries bit b = floor((f-1)/(T2+1)) for f in 1..(T2+1)*WIDTH. Sample s = (f-1) mod (T2+1).
  - Use a slot counter (0..T2) and a bit index (0..WIDTH-1). No dividers.
- Gap samples are cycles f = 0 and f in (T2+1)*WIDTH+1..T1. Each must read 0; a 1 sets idle_err.
- Per bit:
  - ones counter (width clog2(T2+2)) counts 1s over the T2+1 samples.
  - bit = 1 iff 2*ones > T2+1. A tie resolves to 0.
  - If ones is neither 0 nor T2+1, the bit is non-unanimous: set the word's err accumulator and increment glitch_cnt (saturating).
- Bits shift into an accumulator LSB first: bit b goes to position b.
- Word completion happens at the last sample of bit WIDTH-1, at the end of cycle f = (T2+1)*WIDTH.
  - If data_valid=0, or data_valid=1 and data_ready=1 in that cycle: load data_out and data_err, hold data_valid=1.
  - Otherwise keep the held word and set overrun. The new word is dropped.
- Handshake: a transfer occurs in any cycle with data_valid && data_ready.
  - After a transfer, data_valid goes 0 unless a completion loads in the same edge.
  - data_out and data_err stay stable while data_valid && !data_ready.
- Truncation: if frame_cnt wraps (frame_cnt == T1) before completion, set short_frame and clear the accumulator, ones, slot, bit index and err. No word is emitted. This occurs when T1 < (T2+1)*WIDTH.
- Wrap and completion in the same cycle (T1 == (T2+1)*WIDTH): completion wins, short_frame is not set.
- Reset mid-frame: all counters, accumulator, outputs and sticky flags return to 0 on the edge. Any partially collected or held word is discarded.

## Timing
- Bit decisions are registered at the end of each bit's last sample cycle.
- Latency: data_valid first rises in frame cycle (T2+1)*WIDTH+1. With defaults that is cycle 25.
- Word rate: one word per T1+1 cycles.
- Sticky flags set at the edge ending the offending cycle, and clear only on reset.
- glitch_cnt updates at the edge ending the bit's last sample cycle.
- No combinational path from data_ready to data_valid or data_out.

## Test plan
- N=8'hA5, T1=40, T2=2, data_ready=1 -> data_valid rises in cycle 25 with data_out=8'hA5 and data_err=0; again in cycle 66; all flags remain 0.
- Same setup, data_ready=0 until cycle 70 -> data_out holds 8'hA5 through cycle 66, overrun=1; data_valid drops after the cycle-70 transfer.
- Invert signal_in for one cycle in frame cycle 11 (bit 3, slot 1) -> data_out=8'hA5, data_err=1, glitch_cnt=1.
- T1=20 -> data_valid never rises, short_frame=1 after cycle 20; gap checks do not fire.
- Force signal_in=1 in frame cycle 30 -> idle_err=1; the next word is still 8'hA5 with data_err=0.
- Assert reset in cycle 12 for one cycle -> outputs return to 0; the first data_valid appears 25 cycles after reset release, with data_out=8'hA5.
